// File: rtl/draw_snake.sv
// draw_snake: snake game state and pixel overlay stage between draw_apple and MouseDisplay.
//
// Holds a circular segment buffer and a 64x48 occupancy bitmap. A frame-paced FSM moves the
// snake once every FRAMES_PER_STEP vblnk rising edges. Head and body cells are composited
// onto the incoming RGB stream, and the VGA timing signals are forwarded with 2-cycle latency.
//
// Ports:
//   pclk, rst                     pixel clock, asynchronous active-low reset
//   hcount_in/vcount_in, *sync_in, *blnk_in, rgb_in   upstream pixel stream
//   dir                           requested direction (00 right, 01 down, 10 left, 11 up)
//   apple_x, apple_y              apple cell in grid units
//   hcount_out/vcount_out, *sync_out, *blnk_out, rgb_out   stream delayed 2 cycles
//   apple_eaten                   one-cycle pulse when the head enters the apple cell
//   game_over                     sticky collision flag
//   snake_len                     current snake length
module draw_snake #(
    parameter int unsigned MAX_LEN         = 64,
    parameter int unsigned FRAMES_PER_STEP = 8,
    parameter logic [11:0] HEAD_RGB        = 12'h0F0,
    parameter logic [11:0] BODY_RGB        = 12'h080
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [1:0]  dir,
    input  logic [6:0]  apple_x,
    input  logic [5:0]  apple_y,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out,
    output logic        apple_eaten,
    output logic        game_over,
    output logic [6:0]  snake_len
);

    localparam int unsigned PW    = $clog2(MAX_LEN);
    localparam int unsigned FW    = $clog2(FRAMES_PER_STEP + 1);
    localparam int unsigned CELLS = 3072;

    typedef enum logic [3:0] {
        StInit, StSeed, StIdle, StCalc, StRead, StCheck, StWrite, StClear, StDone
    } state_e;

    state_e        state_q;
    logic [11:0]   init_cnt_q;
    logic [FW-1:0] frame_cnt_q;
    logic          vblnk_prev_q;
    logic [PW-1:0] head_ptr_q, tail_ptr_q;
    logic [5:0]    head_x_q, head_y_q, nx_q, ny_q;
    logic [1:0]    cur_dir_q;
    logic          eat_q, occ_fsm_q, init_done_q, game_over_q, apple_eaten_q;
    logic [6:0]    snake_len_q;

    // Bitmap is addressed {y, x}; segments are stored {x, y}.
    logic          bitmap_q [CELLS];
    logic [11:0]   seg_q [MAX_LEN];

    logic [1:0]    dir_eff;
    logic [6:0]    nx_c, ny_c;
    logic          wall_c, eat_c, collide, do_clear;
    logic [11:0]   tail_seg;
    logic [5:0]    seed_x;

    logic          bm_we, bm_wdata, seg_we;
    logic [11:0]   bm_waddr, seg_wdata;
    logic [PW-1:0] seg_waddr;

    assign tail_seg = seg_q[tail_ptr_q];
    assign seed_x   = 6'd10 + init_cnt_q[5:0];
    assign collide  = occ_fsm_q && !(({nx_q, ny_q} == tail_seg) && !eat_q);
    // At full length an eaten apple still retires the tail so the length holds.
    assign do_clear = !eat_q || (snake_len_q == 7'(MAX_LEN));

    // Next head is computed one bit wider so walls are seen before truncation.
    always_comb begin
        dir_eff = (dir == (cur_dir_q ^ 2'b10)) ? cur_dir_q : dir;
        nx_c    = {1'b0, head_x_q};
        ny_c    = {1'b0, head_y_q};
        case (dir_eff)
            2'b00:   nx_c = nx_c + 7'd1;
            2'b01:   ny_c = ny_c + 7'd1;
            2'b10:   nx_c = nx_c - 7'd1;
            default: ny_c = ny_c - 7'd1;
        endcase
        wall_c = nx_c[6] || (ny_c >= 7'd48);
        eat_c  = (nx_c == apple_x) && (ny_c[5:0] == apple_y);
    end

    always_comb begin
        bm_we     = 1'b0;
        bm_waddr  = '0;
        bm_wdata  = 1'b0;
        seg_we    = 1'b0;
        seg_waddr = '0;
        seg_wdata = '0;
        case (state_q)
            StInit: begin
                bm_we    = 1'b1;
                bm_waddr = init_cnt_q;
            end
            StSeed: begin
                bm_we     = 1'b1;
                bm_waddr  = {6'd24, seed_x};
                bm_wdata  = 1'b1;
                seg_we    = 1'b1;
                seg_waddr = PW'(init_cnt_q);
                seg_wdata = {seed_x, 6'd24};
            end
            StWrite: begin
                bm_we     = 1'b1;
                bm_waddr  = {ny_q, nx_q};
                bm_wdata  = 1'b1;
                seg_we    = 1'b1;
                seg_waddr = head_ptr_q + 1'b1;
                seg_wdata = {nx_q, ny_q};
            end
            StClear: begin
                // Tail-follow: the vacated tail is the new head, so keep it set.
                bm_we    = (tail_seg != {head_x_q, head_y_q});
                bm_waddr = {tail_seg[5:0], tail_seg[11:6]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (bm_we) bitmap_q[bm_waddr] <= bm_wdata;
        if (seg_we) seg_q[seg_waddr] <= seg_wdata;
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_q       <= StInit;
            init_cnt_q    <= '0;
            frame_cnt_q   <= '0;
            vblnk_prev_q  <= 1'b0;
            head_ptr_q    <= '0;
            tail_ptr_q    <= '0;
            head_x_q      <= '0;
            head_y_q      <= '0;
            nx_q          <= '0;
            ny_q          <= '0;
            cur_dir_q     <= '0;
            eat_q         <= 1'b0;
            occ_fsm_q     <= 1'b0;
            init_done_q   <= 1'b0;
            game_over_q   <= 1'b0;
            apple_eaten_q <= 1'b0;
            snake_len_q   <= '0;
        end else begin
            apple_eaten_q <= 1'b0;
            vblnk_prev_q  <= vblnk_in;
            case (state_q)
                StInit: begin
                    if (init_cnt_q == 12'(CELLS - 1)) begin
                        init_cnt_q <= '0;
                        state_q    <= StSeed;
                    end else begin
                        init_cnt_q <= init_cnt_q + 12'd1;
                    end
                end
                StSeed: begin
                    head_x_q   <= seed_x;
                    head_y_q   <= 6'd24;
                    head_ptr_q <= PW'(init_cnt_q);
                    if (init_cnt_q == 12'd2) begin
                        tail_ptr_q  <= '0;
                        snake_len_q <= 7'd3;
                        cur_dir_q   <= 2'b00;
                        init_done_q <= 1'b1;
                        state_q     <= StIdle;
                    end else begin
                        init_cnt_q <= init_cnt_q + 12'd1;
                    end
                end
                StIdle: begin
                    if (vblnk_in && !vblnk_prev_q) begin
                        if (frame_cnt_q == FW'(FRAMES_PER_STEP - 1)) begin
                            frame_cnt_q <= '0;
                            if (!game_over_q) state_q <= StCalc;
                        end else begin
                            frame_cnt_q <= frame_cnt_q + 1'b1;
                        end
                    end
                end
                StCalc: begin
                    cur_dir_q <= dir_eff;
                    nx_q      <= nx_c[5:0];
                    ny_q      <= ny_c[5:0];
                    eat_q     <= eat_c;
                    if (wall_c) begin
                        game_over_q <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        state_q <= StRead;
                    end
                end
                StRead: begin
                    occ_fsm_q <= bitmap_q[{ny_q, nx_q}];
                    state_q   <= StCheck;
                end
                StCheck: begin
                    if (collide) begin
                        game_over_q <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        state_q <= StWrite;
                    end
                end
                StWrite: begin
                    head_ptr_q <= head_ptr_q + 1'b1;
                    head_x_q   <= nx_q;
                    head_y_q   <= ny_q;
                    if (do_clear) begin
                        state_q <= StClear;
                    end else begin
                        apple_eaten_q <= 1'b1;
                        snake_len_q   <= snake_len_q + 7'd1;
                        state_q       <= StDone;
                    end
                end
                StClear: begin
                    tail_ptr_q    <= tail_ptr_q + 1'b1;
                    apple_eaten_q <= eat_q;
                    state_q       <= StDone;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Draw pipeline: stage 1 reads the bitmap, stage 2 composites.
    logic        in_grid, draw_occ, head_hit;
    logic [11:0] draw_idx;
    logic [10:0] h1_q, v1_q;
    logic        hs1_q, vs1_q, hb1_q, vb1_q, occ1_q, head1_q, grid1_q;
    logic [11:0] rgb1_q;
    logic [10:0] hcount_q, vcount_q;
    logic        hsync_q, vsync_q, hblnk_q, vblnk_q;
    logic [11:0] rgb_q;

    assign in_grid  = (hcount_in < 11'd1024) && (vcount_in < 11'd768);
    assign draw_idx = {vcount_in[9:4], hcount_in[9:4]};
    assign draw_occ = in_grid ? bitmap_q[draw_idx] : 1'b0;
    assign head_hit = (hcount_in[9:4] == head_x_q) && (vcount_in[9:4] == head_y_q);

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            h1_q     <= '0;
            v1_q     <= '0;
            hs1_q    <= 1'b0;
            vs1_q    <= 1'b0;
            hb1_q    <= 1'b0;
            vb1_q    <= 1'b0;
            rgb1_q   <= '0;
            occ1_q   <= 1'b0;
            head1_q  <= 1'b0;
            grid1_q  <= 1'b0;
            hcount_q <= '0;
            vcount_q <= '0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            hblnk_q  <= 1'b0;
            vblnk_q  <= 1'b0;
            rgb_q    <= '0;
        end else begin
            h1_q     <= hcount_in;
            v1_q     <= vcount_in;
            hs1_q    <= hsync_in;
            vs1_q    <= vsync_in;
            hb1_q    <= hblnk_in;
            vb1_q    <= vblnk_in;
            rgb1_q   <= rgb_in;
            occ1_q   <= draw_occ;
            head1_q  <= head_hit;
            grid1_q  <= in_grid;
            hcount_q <= h1_q;
            vcount_q <= v1_q;
            hsync_q  <= hs1_q;
            vsync_q  <= vs1_q;
            hblnk_q  <= hb1_q;
            vblnk_q  <= vb1_q;
            if (hb1_q || vb1_q) begin
                rgb_q <= '0;
            end else if (grid1_q && occ1_q && init_done_q) begin
                rgb_q <= head1_q ? HEAD_RGB : BODY_RGB;
            end else begin
                rgb_q <= rgb1_q;
            end
        end
    end

    assign hcount_out  = hcount_q;
    assign vcount_out  = vcount_q;
    assign hsync_out   = hsync_q;
    assign vsync_out   = vsync_q;
    assign hblnk_out   = hblnk_q;
    assign vblnk_out   = vblnk_q;
    assign rgb_out     = rgb_q;
    assign apple_eaten = apple_eaten_q;
    assign game_over   = game_over_q;
    assign snake_len   = snake_len_q;

endmodule

// File: tb/tb_draw_snake.sv
// Bench for draw_snake: directed scenarios plus random walks checked against a queue model.
module tb_draw_snake;
    localparam int          MAX_LEN = 64;
    localparam int          FPS     = 8;
    localparam logic [11:0] HEAD    = 12'h0F0;
    localparam logic [11:0] BODY    = 12'h080;

    logic        pclk      = 1'b0;
    logic        rst       = 1'b0;
    logic [10:0] hcount_in = '0;
    logic [10:0] vcount_in = '0;
    logic        hsync_in  = 1'b0;
    logic        vsync_in  = 1'b0;
    logic        hblnk_in  = 1'b0;
    logic        vblnk_in  = 1'b0;
    logic [11:0] rgb_in    = '0;
    logic [1:0]  dir       = '0;
    logic [6:0]  apple_x   = 7'd100;
    logic [5:0]  apple_y   = '0;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;
    logic        apple_eaten, game_over;
    logic [6:0]  snake_len;

    always #5 pclk = ~pclk;

    draw_snake #(
        .MAX_LEN(MAX_LEN), .FRAMES_PER_STEP(FPS), .HEAD_RGB(HEAD), .BODY_RGB(BODY)
    ) dut (
        .pclk(pclk), .rst(rst),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .dir(dir), .apple_x(apple_x), .apple_y(apple_y),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out), .apple_eaten(apple_eaten), .game_over(game_over),
        .snake_len(snake_len)
    );

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int eaten_cnt = 0;

    always @(posedge pclk) if (apple_eaten === 1'b1) eaten_cnt <= eaten_cnt + 1;

    // Reference model: cells keyed x*64+y, index 0 is the tail, last entry the head.
    int snake_m[$];
    int cur_m;
    bit over_m;
    bit live_m;
    int eat_total_m = 0;

    logic [10:0] hv [20];
    logic [10:0] vv [20];
    logic [3:0]  sv [20];
    logic [11:0] rv [20];

    function automatic void model_reset();
        snake_m = {10 * 64 + 24, 11 * 64 + 24, 12 * 64 + 24};
        cur_m   = 0;
        over_m  = 1'b0;
        live_m  = 1'b0;
    endfunction

    function automatic void model_step(input int d, input int ax, input int ay);
        int nx, ny, nk;
        bit eat, occ;
        if (over_m) return;
        if (d != (cur_m ^ 2)) cur_m = d;
        nx = snake_m[$] / 64;
        ny = snake_m[$] % 64;
        case (cur_m)
            0: nx = nx + 1;
            1: ny = ny + 1;
            2: nx = nx - 1;
            default: ny = ny - 1;
        endcase
        if (nx < 0 || nx > 63 || ny < 0 || ny > 47) begin
            over_m = 1'b1;
            return;
        end
        eat = (nx == ax) && (ny == ay);
        nk  = nx * 64 + ny;
        occ = 1'b0;
        foreach (snake_m[i]) if (snake_m[i] == nk) occ = 1'b1;
        if (occ && !(nk == snake_m[0] && !eat)) begin
            over_m = 1'b1;
            return;
        end
        snake_m.push_back(nk);
        if (eat) eat_total_m++;
        if (!eat || snake_m.size() > MAX_LEN) void'(snake_m.pop_front());
    endfunction

    function automatic logic [11:0] exp_rgb(input int hc, input int vc, input bit hb,
                                            input bit vb, input logic [11:0] rgb);
        int k;
        if (hb || vb) return 12'h000;
        if (live_m && hc < 1024 && vc < 768) begin
            k = (hc / 16) * 64 + (vc / 16);
            if (k == snake_m[$]) return HEAD;
            foreach (snake_m[i]) if (snake_m[i] == k) return BODY;
        end
        return rgb;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic probe(input string tag, input int hc, input int vc);
        logic [11:0] r;
        logic [11:0] e;
        r = 12'($urandom);
        @(negedge pclk);
        hcount_in = 11'(hc);
        vcount_in = 11'(vc);
        rgb_in    = r;
        hblnk_in  = 1'b0;
        vblnk_in  = 1'b0;
        e = exp_rgb(hc, vc, 1'b0, 1'b0, r);
        repeat (2) @(negedge pclk);
        chk(tag, 32'(rgb_out), 32'(e));
    endtask

    task automatic probe_cell(input string tag, input int x, input int y);
        probe(tag, x * 16 + int'($urandom_range(0, 15)), y * 16 + int'($urandom_range(0, 15)));
    endtask

    task automatic pulse();
        @(negedge pclk);
        vblnk_in = 1'b1;
        repeat (2) @(negedge pclk);
        vblnk_in = 1'b0;
        @(negedge pclk);
    endtask

    task automatic step(input int d, input int ax, input int ay);
        dir     = 2'(d);
        apple_x = 7'(ax);
        apple_y = 6'(ay);
        for (int f = 0; f < FPS; f++) pulse();
        repeat (10) @(negedge pclk);
        model_step(d, ax, ay);
    endtask

    task automatic check_state(input string tag);
        chk({tag, " len"}, 32'(snake_len), live_m ? 32'(snake_m.size()) : 32'd0);
        chk({tag, " over"}, 32'(game_over), 32'(over_m));
        chk({tag, " eaten"}, 32'(eaten_cnt), 32'(eat_total_m));
        probe_cell({tag, " head"}, snake_m[$] / 64, snake_m[$] % 64);
        probe_cell({tag, " tail"}, snake_m[0] / 64, snake_m[0] % 64);
        probe_cell({tag, " rand"}, int'($urandom_range(0, 63)), int'($urandom_range(0, 47)));
    endtask

    task automatic do_reset();
        @(negedge pclk);
        rst = 1'b0;
        repeat (3) @(negedge pclk);
        rst = 1'b1;
        model_reset();
        repeat (3100) @(negedge pclk);
        live_m = 1'b1;
    endtask

    task automatic random_walk(input string tag, input int n);
        int ax, ay;
        do_reset();
        for (int s = 0; s < n; s++) begin
            ax = snake_m[$] / 64 + int'($urandom_range(0, 4)) - 2;
            ay = snake_m[$] % 64 + int'($urandom_range(0, 4)) - 2;
            step(int'($urandom_range(0, 3)), ax, ay);
            check_state(tag);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        // Reset held from time zero.
        repeat (2) @(negedge pclk);
        chk("rst len", 32'(snake_len), 32'd0);
        chk("rst over", 32'(game_over), 32'd0);
        chk("rst eaten", 32'(apple_eaten), 32'd0);
        chk("rst rgb", 32'(rgb_out), 32'd0);
        rst = 1'b1;
        repeat (100) @(negedge pclk);
        chk("init len", 32'(snake_len), 32'd0);
        probe("init masked", 200, 392);
        repeat (3900) @(negedge pclk);
        live_m = 1'b1;
        chk("seed len", 32'(snake_len), 32'd3);
        probe("seed head", 200, 392);
        probe("seed body", 168, 392);
        probe("origin", 0, 0);

        // Timing outputs must lag inputs by exactly 2 cycles.
        for (int i = 0; i < 20; i++) begin
            @(negedge pclk);
            if (i >= 2) begin
                chk("lat hcount", 32'(hcount_out), 32'(hv[i-2]));
                chk("lat vcount", 32'(vcount_out), 32'(vv[i-2]));
                chk("lat syncs", 32'({hsync_out, vsync_out, hblnk_out, vblnk_out}),
                    32'(sv[i-2]));
                chk("lat rgb", 32'(rgb_out),
                    32'(exp_rgb(int'(hv[i-2]), int'(vv[i-2]), sv[i-2][1], 1'b0, rv[i-2])));
            end
            hv[i] = 11'($urandom);
            vv[i] = 11'($urandom_range(0, 900));
            sv[i] = {2'($urandom), 1'($urandom), 1'b0};
            rv[i] = 12'($urandom);
            hcount_in = hv[i];
            vcount_in = vv[i];
            {hsync_in, vsync_in, hblnk_in, vblnk_in} = sv[i];
            rgb_in = rv[i];
        end

        step(0, 100, 0);
        step(0, 100, 0);
        check_state("right2");
        probe_cell("vacated10", 10, 24);
        probe_cell("vacated11", 11, 24);
        step(2, 100, 0);
        check_state("reverse");
        step(1, 100, 0);
        check_state("turn down");

        // Eat once, then two tail-follow moves around a 2x2 square.
        do_reset();
        step(0, 13, 24);
        check_state("eat");
        probe_cell("eat oldtail", 10, 24);
        step(1, 100, 0);
        step(2, 100, 0);
        step(3, 100, 0);
        check_state("tailfollow1");
        step(0, 100, 0);
        check_state("tailfollow2");

        // Grow to five and bite the body.
        do_reset();
        step(0, 13, 24);
        step(0, 14, 24);
        step(1, 100, 0);
        step(2, 100, 0);
        step(3, 100, 0);
        check_state("selfhit");
        for (int s = 0; s < 3; s++) step(0, 100, 0);
        check_state("selfhit frozen");

        // Run into the right wall.
        do_reset();
        for (int s = 0; s < 52; s++) step(0, 100, 0);
        check_state("wall");
        for (int s = 0; s < 3; s++) step(1, 100, 0);
        check_state("wall frozen");

        // Reset in the middle of a move (CLEAR state).
        do_reset();
        hcount_in = 11'd300;
        hsync_in  = 1'b1;
        dir       = 2'b00;
        apple_x   = 7'd100;
        for (int f = 0; f < FPS - 1; f++) pulse();
        @(negedge pclk);
        vblnk_in = 1'b1;
        repeat (5) @(negedge pclk);
        rst = 1'b0;
        #1;
        chk("midrst len", 32'(snake_len), 32'd0);
        chk("midrst hcount", 32'(hcount_out), 32'd0);
        chk("midrst hsync", 32'(hsync_out), 32'd0);
        chk("midrst rgb", 32'(rgb_out), 32'd0);
        vblnk_in = 1'b0;
        hsync_in = 1'b0;
        repeat (2) @(negedge pclk);
        rst = 1'b1;
        model_reset();
        repeat (3100) @(negedge pclk);
        live_m = 1'b1;
        check_state("after midrst");
        probe("after midrst body", 168, 392);

        random_walk("walkA", 30);
        random_walk("walkB", 30);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
